// File: rtl/led_sequencer.sv
// Three-LED status sequencer: prescaled step tick plus four display patterns
// (blink, alternate, chase, bounce) selected by a mode-advance pulse.
module led_sequencer #(
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       MODE_NEXT,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic [1:0] MODE,
    output logic       TICK
);

    typedef enum logic [1:0] {
        M_BLINK  = 2'd0,
        M_ALT    = 2'd1,
        M_CHASE  = 2'd2,
        M_BOUNCE = 2'd3
    } mode_e;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

    mode_e            mode_q, mode_d;
    logic [2:0]       pat_q, pat_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;

    function automatic logic [2:0] init_pat(input mode_e m);
        case (m)
            M_BLINK: init_pat = 3'b000;
            M_ALT:   init_pat = 3'b101;
            default: init_pat = 3'b001;
        endcase
    endfunction

    // Returns {dir, pat} after one step; any off-sequence pattern restarts
    // the mode from its initial pattern.
    function automatic logic [3:0] step_pat(input mode_e m, input logic [2:0] p,
                                            input logic d);
        step_pat = {1'b0, init_pat(m)};
        case (m)
            M_BLINK: if (p == 3'b000) step_pat = {1'b0, 3'b111};
            M_ALT:   if (p == 3'b101) step_pat = {1'b0, 3'b010};
            M_CHASE: begin
                if (p == 3'b001)      step_pat = {1'b0, 3'b010};
                else if (p == 3'b010) step_pat = {1'b0, 3'b100};
            end
            M_BOUNCE: begin
                if (p == 3'b001)                step_pat = {1'b0, 3'b010};
                else if (p == 3'b010 && !d)     step_pat = {1'b1, 3'b100};
                else if (p == 3'b100)           step_pat = {1'b1, 3'b010};
            end
            default: step_pat = {1'b0, 3'b000};
        endcase
    endfunction

    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        // A mode advance overrides a coincident step.
        if (MODE_NEXT) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pat_d  = init_pat(mode_e'(mode_q + 2'd1));
            cnt_d  = '0;
            dir_d  = 1'b0;
        end else if (EN) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d          = '0;
                {dir_d, pat_d} = step_pat(mode_q, pat_q, dir_q);
                tick_d         = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q <= M_BLINK;
            pat_q  <= 3'b000;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign {LED2, LED1, LED0} = pat_q;
    assign MODE               = mode_q;
    assign TICK               = tick_q;

endmodule
